led_shift_out: RTL and testbench

Downstream stage of the LED step counter: watches the 8-bit `LED` bus and, whenever its value changes, serialises the new value to an external 74HC595-style shift register. The serial interface has three lines: `sclk`, `sdata` and `slatch`. The block sits between the counter and the board pins, so the counter needs no knowledge of the physical LED driver. Values that change faster than a transfer completes are coalesced: only the most recent value is sent, and each skipped change is counted.

---
 rtl/led_shift_out.sv | 182 ++++++++++++++++++
 tb/tb_led_shift_out.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_shift_out.sv
// led_shift_out
//   Watches the LED bus and, whenever its value differs from the last value
//   sent, serialises it to a 74HC595-style shift register. The serial lines
//   are sclk, sdata and slatch. Changes that arrive while a transfer is in
//   flight are not queued: on return to IDLE only the current LED value is
//   compared and sent, and every change seen while busy is counted.
//
// Parameters
//   WIDTH     : bits per transfer (width of LED)
//   CLKDIV    : CLK cycles per sclk half-period and per latch pulse (>= 1)
//   MSB_FIRST : 1 = shift bit WIDTH-1 first, 0 = shift bit 0 first
//
// Ports
//   CLK       in   system clock, rising edge
//   RST       in   asynchronous active-high reset
//   LED       in   value to display
//   sclk      out  serial clock (external register samples on rising edge)
//   sdata     out  serial data
//   slatch    out  storage-register latch pulse, active high
//   busy      out  high while a transfer is in progress
//   coalesced out  saturating count of LED changes seen while busy
module led_shift_out #(
  parameter int WIDTH     = 8,
  parameter int CLKDIV    = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] LED,
  output logic             sclk,
  output logic             sdata,
  output logic             slatch,
  output logic             busy,
  output logic [7:0]       coalesced
);

  localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLKDIV - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO = '0;
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   last_q, last_d;
  logic               force_q, force_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   led_q;
  logic [7:0]         coal_q, coal_d;
  logic               sclk_q, sclk_d;
  logic               sdata_q, sdata_d;
  logic               slatch_q, slatch_d;
  logic               busy_q, busy_d;

  // Bit presented on sdata and the shifted register, chosen by direction.
  logic               first_bit_d;
  logic [WIDTH-1:0]   shift_adv;

  generate
    if (MSB_FIRST) begin : g_msb
      assign first_bit_d = shift_d[WIDTH-1];
      assign shift_adv   = shift_q << 1;
    end else begin : g_lsb
      assign first_bit_d = shift_d[0];
      assign shift_adv   = shift_q >> 1;
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    last_d   = last_q;
    force_d  = force_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    coal_d   = coal_q;

    case (state_q)
      IDLE: begin
        if (force_q || (LED != last_q)) begin
          shift_d = LED;
          last_d  = LED;
          force_d = 1'b0;
          cnt_d   = CNT_LOAD;
          div_d   = DIV_LOAD;
          state_d = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div_q == DIV_ZERO) begin
          div_d   = DIV_LOAD;
          state_d = SHIFT_HI;
        end else begin
          div_d = div_q - DIV_ONE;
        end
      end
      SHIFT_HI: begin
        if (div_q == DIV_ZERO) begin
          div_d = DIV_LOAD;
          cnt_d = cnt_q - CNT_ONE;
          // cnt_q == 1 means the bit just clocked out was the last one.
          if (cnt_q != CNT_ONE) begin
            shift_d = shift_adv;
            state_d = SHIFT_LO;
          end else begin
            state_d = LATCH;
          end
        end else begin
          div_d = div_q - DIV_ONE;
        end
      end
      LATCH: begin
        if (div_q == DIV_ZERO) begin
          state_d = IDLE;
        end else begin
          div_d = div_q - DIV_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Changes are counted against the previous-cycle copy, not last_sent,
    // so every intermediate value that gets dropped is accounted for.
    if (busy_q && (LED != led_q) && (coal_q != 8'hFF)) begin
      coal_d = coal_q + 8'd1;
    end

    // Outputs are registered from the next state so they line up with it.
    sclk_d   = (state_d == SHIFT_HI);
    slatch_d = (state_d == LATCH);
    busy_d   = (state_d != IDLE);
    sdata_d  = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) ? first_bit_d : 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      last_q   <= '0;
      force_q  <= 1'b1;
      div_q    <= '0;
      cnt_q    <= '0;
      led_q    <= '0;
      coal_q   <= '0;
      sclk_q   <= 1'b0;
      sdata_q  <= 1'b0;
      slatch_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      last_q   <= last_d;
      force_q  <= force_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      led_q    <= LED;
      coal_q   <= coal_d;
      sclk_q   <= sclk_d;
      sdata_q  <= sdata_d;
      slatch_q <= slatch_d;
      busy_q   <= busy_d;
    end
  end

  assign sclk      = sclk_q;
  assign sdata     = sdata_q;
  assign slatch    = slatch_q;
  assign busy      = busy_q;
  assign coalesced = coal_q;

endmodule

// File: tb/tb_led_shift_out.sv
// tb_led_shift_out
//   Two instances (MSB-first and LSB-first) share CLK, RST and LED. A
//   transfer-level model predicts every output each cycle; directed scenarios
//   plus a random phase drive the stimulus, and literal expectations pin the
//   model (transfer length, latch width, shifted words, saturation).
module tb_led_shift_out;

  localparam int C   = 2;
  localparam int W   = 8;
  localparam int SHB = 2 * C * W;      // cycles spent shifting
  localparam int TOT = SHB + C;        // total busy cycles per transfer

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] led = 8'h00;

  logic       sclk_m, sdata_m, slatch_m, busy_m;
  logic [7:0] coal_m;
  logic       sclk_l, sdata_l, slatch_l, busy_l;
  logic [7:0] coal_l;

  led_shift_out #(.WIDTH(W), .CLKDIV(C), .MSB_FIRST(1'b1)) u_msb (
    .CLK(clk), .RST(rst), .LED(led),
    .sclk(sclk_m), .sdata(sdata_m), .slatch(slatch_m), .busy(busy_m),
    .coalesced(coal_m)
  );

  led_shift_out #(.WIDTH(W), .CLKDIV(C), .MSB_FIRST(1'b0)) u_lsb (
    .CLK(clk), .RST(rst), .LED(led),
    .sclk(sclk_l), .sdata(sdata_l), .slatch(slatch_l), .busy(busy_l),
    .coalesced(coal_l)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transfer-level model ----------------
  int         k      = 0;      // position inside a transfer, 0 = idle
  logic [7:0] m_val  = 8'h00;
  logic [7:0] m_last = 8'h00;
  logic [7:0] m_prev = 8'h00;
  logic       m_force = 1'b1;
  int         m_coal = 0;

  // ---------------- observers ----------------
  logic [7:0] acc = 0, lacc = 0, last_word = 0, last_lsb = 0;
  int latch_count = 0, busy_run = 0, idle_run = 0, last_busy_len = 0, last_gap = 0;
  int latch_run = 0, last_latch_len = 0;
  logic p_sclk = 0, p_sclkl = 0, p_latch = 0, p_busy = 0;

  initial begin : cmp
    int idx;
    logic e_busy, e_sclk, e_sdm, e_sdl, e_lat;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        k = 0; m_last = 0; m_prev = 0; m_force = 1; m_coal = 0;
      end else begin
        if (k > 0 && led != m_prev && m_coal < 255) m_coal++;
        m_prev = led;
        if (k == 0) begin
          if (m_force || led != m_last) begin
            m_val = led; m_last = led; m_force = 0; k = 1;
          end
        end else if (k == TOT) begin
          k = 0;
        end else begin
          k++;
        end
      end
      #1;
      e_busy = (k > 0); e_sclk = 0; e_sdm = 0; e_sdl = 0; e_lat = 0;
      if (k >= 1 && k <= SHB) begin
        idx    = (k - 1) / (2 * C);
        e_sclk = ((k - 1) % (2 * C)) >= C;
        e_sdm  = m_val[W-1-idx];
        e_sdl  = m_val[idx];
      end else if (k > SHB) begin
        e_lat = 1;
      end
      check("busy", busy_m, e_busy);
      check("sclk", sclk_m, e_sclk);
      check("sdata_msb", sdata_m, e_sdm);
      check("slatch", slatch_m, e_lat);
      check("coalesced", coal_m, m_coal);
      check("sdata_lsb", sdata_l, e_sdl);
      check("busy_lsb", busy_l, e_busy);

      if (rst) begin
        acc = 0; lacc = 0;
      end else begin
        if (sclk_m && !p_sclk)  acc  = {acc[6:0], sdata_m};
        if (sclk_l && !p_sclkl) lacc = {sdata_l, lacc[7:1]};
        if (slatch_m && !p_latch) begin
          latch_count++; last_word = acc; last_lsb = lacc;
        end
      end
      if (busy_m) begin
        if (!p_busy) begin last_gap = idle_run; busy_run = 0; end
        busy_run++; idle_run = 0;
      end else begin
        if (p_busy) last_busy_len = busy_run;
        idle_run++;
      end
      if (slatch_m) latch_run++;
      else begin
        if (p_latch) last_latch_len = latch_run;
        latch_run = 0;
      end
      p_sclk = sclk_m; p_sclkl = sclk_l; p_latch = slatch_m; p_busy = busy_m;
    end
  end

  task automatic wait_high(input string name);
    int n = 0;
    while (!busy_m && n < 20) begin @(negedge clk); n++; end
    check({name, "_start"}, busy_m, 1);
  endtask

  task automatic wait_low(input string name);
    int n = 0;
    while (busy_m && n < 200) begin @(negedge clk); n++; end
    check({name, "_end"}, busy_m, 0);
  endtask

  task automatic wait_done(input string name);
    wait_high(name);
    wait_low(name);
  endtask

  initial begin : stim
    int lc, c0, bad;
    repeat (3) @(negedge clk);
    rst = 0;

    // Power-up forced transfer of 0x00.
    wait_done("powerup");
    check("powerup_busy_len", last_busy_len, 34);
    check("powerup_latch_len", last_latch_len, 2);
    check("powerup_word", last_word, 8'h00);
    check("powerup_latches", latch_count, 1);

    // Value change 0x00 -> 0xA5.
    repeat (3) @(negedge clk);
    led = 8'hA5;
    wait_done("a5");
    check("a5_word", last_word, 8'hA5);
    check("a5_latches", latch_count, 2);

    // Coalescing: three changes during one transfer -> one follow-up of 0x03.
    repeat (3) @(negedge clk);
    lc = latch_count;
    led = 8'h10;
    wait_high("coal_first");
    repeat (3) @(negedge clk);
    c0 = coal_m;
    led = 8'h01; repeat (2) @(negedge clk);
    led = 8'h02; repeat (2) @(negedge clk);
    led = 8'h03;
    wait_low("coal_first");
    wait_done("coal_second");
    check("coal_word", last_word, 8'h03);
    check("coal_gap", last_gap, 1);
    check("coal_delta", coal_m - c0, 3);
    repeat (20) @(negedge clk);
    check("coal_latches", latch_count, lc + 2);

    // Reset during bit 4, while sclk is high.
    led = 8'h5C;
    wait_high("rst_mid");
    repeat (15) @(negedge clk);
    check("rst_mid_sclk_before", sclk_m, 1);
    lc = latch_count;
    rst = 1;
    #1;
    check("rst_sclk", sclk_m, 0);
    check("rst_sdata", sdata_m, 0);
    check("rst_slatch", slatch_m, 0);
    check("rst_busy", busy_m, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    wait_done("rst_forced");
    check("rst_latches", latch_count, lc + 1);
    check("rst_word", last_word, 8'h5C);

    // Stable input.
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (busy_m || sclk_m || slatch_m) bad++;
    end
    check("stable_quiet", bad, 0);

    // Saturation of the coalesced counter.
    led = 8'h33;
    wait_high("sat");
    repeat (340) begin @(negedge clk); led = ~led; end
    repeat (90) @(negedge clk);
    check("sat_count", coal_m, 255);
    check("sat_idle", busy_m, 0);

    // LSB-first: 0x01 puts the 1 at the first sclk rise.
    led = 8'h01;
    wait_done("lsb");
    check("lsb_word", last_lsb, 8'h01);
    check("msb_word_01", last_word, 8'h01);

    // Random phase with occasional resets and returns to the last value.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (rst) rst = 0;
      else if ($urandom_range(0, 249) == 0) rst = 1;
      case ($urandom_range(0, 15))
        0: led = 8'($urandom);
        1: led = 8'($urandom_range(0, 3));
        default: ;
      endcase
    end
    rst = 0;
    repeat (90) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
